mem_stage_assoc: RTL and testbench

Parametrised successor to the pipeline memory stage. It sits between EXE and WB. It combines three things: a 2-way set-associative, write-through, no-write-allocate data cache with per-set LRU; a multi-halfword SRAM sequencer with a configurable wait-state count; and a freeze handshake (`Ready`) that stalls the pipeline on misses and writes. Read hits complete in zero stall cycles. Read misses fetch a full 64-bit line (four SRAM halfwords).

---
 rtl/mem_stage_assoc_pkg.sv | 26 ++
 rtl/cache_2way.sv | 86 ++++++++
 rtl/mem_stage_assoc.sv | 175 +++++++++++++++++
 tb/tb_mem_stage_assoc.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_assoc_pkg.sv
// Shared types and constants for the associative memory stage.
package mem_stage_pkg;

  // Sequencer states: idle/lookup, line fill, word write-through, one-cycle release.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  // A cache line is 64 bits: four SRAM halfwords, two per 32-bit word.
  localparam int HW_PER_LINE = 4;
  localparam int HW_PER_WORD = 2;

  // Index bits needed to address SETS sets.
  function automatic int index_width(input int sets);
    return $clog2(sets);
  endfunction

  // Tag bits: everything above the 8-byte line offset and the index.
  function automatic int tag_width(input int sets);
    return 32 - 3 - $clog2(sets);
  endfunction

endpackage

// File: rtl/cache_2way.sv
// Two-way set-associative line store with per-set LRU bit.
// Lookup is combinational; fill, word update and LRU changes happen on clk.
module cache_2way
  import mem_stage_pkg::*;
#(
  parameter int SETS  = 64,
  parameter int IDX_W = index_width(SETS),
  parameter int TAG_W = tag_width(SETS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] index,
  input  logic [TAG_W-1:0] tag,
  input  logic             word_sel,
  input  logic             touch,
  input  logic             fill,
  input  logic [63:0]      fill_line,
  input  logic             update_word,
  input  logic [31:0]      update_data,
  output logic             hit,
  output logic             hit_way,
  output logic [31:0]      rdata
);

  // lru_reg[set] names the victim way for that set.
  logic [SETS-1:0]  lru_reg;
  logic [1:0]       way_hit;
  logic [1:0][63:0] way_line;
  logic             victim;

  assign victim = lru_reg[index];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_way
      logic [TAG_W-1:0] tag_arr  [SETS];
      logic [63:0]      data_arr [SETS];
      logic [SETS-1:0]  valid_reg;
      logic             install;

      assign install      = fill && (victim == 1'(gi));
      assign way_hit[gi]  = valid_reg[index] && (tag_arr[index] == tag);
      assign way_line[gi] = data_arr[index];

      // Valid bits clear on reset; a fill marks the installed line valid.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          valid_reg <= '0;
        end else if (install) begin
          valid_reg[index] <= 1'b1;
        end
      end

      // Tag/data storage: whole-line install on fill, single-word patch on store hit.
      always_ff @(posedge clk) begin
        if (install) begin
          tag_arr[index]  <= tag;
          data_arr[index] <= fill_line;
        end else if (update_word && way_hit[gi]) begin
          if (word_sel) begin
            data_arr[index][63:32] <= update_data;
          end else begin
            data_arr[index][31:0] <= update_data;
          end
        end
      end
    end
  endgenerate

  assign hit     = |way_hit;
  assign hit_way = way_hit[1];
  assign rdata   = word_sel ? way_line[hit_way][63:32] : way_line[hit_way][31:0];

  // LRU: flip on fill and on store hit; a read hit makes the other way the victim.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lru_reg <= '0;
    end else if (fill) begin
      lru_reg[index] <= ~lru_reg[index];
    end else if (update_word && hit) begin
      lru_reg[index] <= ~lru_reg[index];
    end else if (touch && hit) begin
      lru_reg[index] <= ~hit_way;
    end
  end

endmodule

// File: rtl/mem_stage_assoc.sv
// Pipeline memory stage: 2-way write-through cache in front of a 16-bit SRAM,
// with a Ready freeze while a line fill or a store is in progress.
// The cycle in which a miss/store is first seen in IDLE already counts as the
// first cycle of the first SRAM access window, so stalls are exactly
// 4*SRAM_WAIT (fill) and 2*SRAM_WAIT (store) cycles.
module mem_stage_assoc
  import mem_stage_pkg::*;
#(
  parameter int ADDR_BASE = 1024,
  parameter int SETS      = 64,
  parameter int SRAM_AW   = 18,
  parameter int SRAM_WAIT = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        ALU_res,
  input  logic [31:0]        Val_Rm,
  input  logic               Mem_R_EN,
  input  logic               Mem_W_EN,
  input  logic               WB_EN_IN,
  inout  wire  [15:0]        SRAM_data,
  output logic               SRAM_WE_N,
  output logic [SRAM_AW-1:0] SRAM_addr,
  output logic               Ready,
  output logic [31:0]        data_mem,
  output logic               WB_EN_OUT
);

  localparam int IDX_W = index_width(SETS);
  localparam int TAG_W = tag_width(SETS);
  localparam int WW    = (SRAM_WAIT > 1) ? $clog2(SRAM_WAIT) : 1;

  // Address decode
  logic [31:0]      a;
  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic             word_sel;
  logic [30:0]      line_hw;
  logic [30:0]      word_hw;
  logic [SRAM_AW-1:0] hw_off;

  assign a        = ALU_res - 32'(ADDR_BASE);
  assign idx      = a[3 +: IDX_W];
  assign tag      = a[31 -: TAG_W];
  assign word_sel = a[2];
  assign line_hw  = {a[31:3], 2'b00};
  assign word_hw  = {a[31:2], 1'b0};

  state_t          state_reg, state_next;
  logic [WW-1:0]   wait_cnt_reg, wait_cnt_next;
  logic [1:0]      hw_cnt_reg, hw_cnt_next;
  logic [3:0][15:0] line_buf;

  logic hit, hit_way;
  logic [31:0] rdata;
  logic req_r, req_w;
  logic fill_active, write_active, last_cyc, fill_done, write_done;

  assign hw_off = {{(SRAM_AW-2){1'b0}}, hw_cnt_reg};

  // Requests are ignored while reset is held so outputs go idle at once.
  assign req_w        = Mem_W_EN & ~rst;
  assign req_r        = Mem_R_EN & ~Mem_W_EN & ~rst;
  assign fill_active  = (state_reg == FILL)  | ((state_reg == IDLE) & req_r & ~hit);
  assign write_active = (state_reg == WRITE) | ((state_reg == IDLE) & req_w);
  assign last_cyc     = (wait_cnt_reg == WW'(SRAM_WAIT - 1));
  assign fill_done    = fill_active  & last_cyc & (hw_cnt_reg == 2'(HW_PER_LINE - 1));
  assign write_done   = write_active & last_cyc & (hw_cnt_reg == 2'(HW_PER_WORD - 1));

  cache_2way #(
    .SETS  (SETS),
    .IDX_W (IDX_W),
    .TAG_W (TAG_W)
  ) u_cache (
    .clk         (clk),
    .rst         (rst),
    .index       (idx),
    .tag         (tag),
    .word_sel    (word_sel),
    .touch       ((state_reg == IDLE) & req_r & hit),
    .fill        (fill_done),
    .fill_line   ({SRAM_data, line_buf[2], line_buf[1], line_buf[0]}),
    .update_word (write_done & hit),
    .update_data (Val_Rm),
    .hit         (hit),
    .hit_way     (hit_way),
    .rdata       (rdata)
  );

  // State and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      wait_cnt_reg <= '0;
      hw_cnt_reg   <= '0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      hw_cnt_reg   <= hw_cnt_next;
    end
  end

  // Next state and SRAM window/halfword sequencing.
  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    hw_cnt_next   = hw_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (write_active)     state_next = WRITE;
        else if (fill_active) state_next = FILL;
      end
      FILL:    if (fill_done)  state_next = DONE;
      WRITE:   if (write_done) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (fill_active | write_active) begin
      if (last_cyc) begin
        wait_cnt_next = '0;
        hw_cnt_next   = (fill_done | write_done) ? 2'd0 : hw_cnt_reg + 2'd1;
      end else begin
        wait_cnt_next = wait_cnt_reg + WW'(1);
      end
    end
  end

  // Line buffer: each slot captures its halfword on the last cycle of its window.
  generate
    for (genvar gi = 0; gi < HW_PER_LINE; gi++) begin : g_lbuf
      logic [15:0] hw_reg;
      assign line_buf[gi] = hw_reg;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          hw_reg <= '0;
        end else if (fill_active && last_cyc && (hw_cnt_reg == 2'(gi))) begin
          hw_reg <= SRAM_data;
        end
      end
    end
  endgenerate

  // Pipeline-facing outputs and SRAM address/strobe.
  always_comb begin
    Ready     = 1'b0;
    data_mem  = 32'd0;
    SRAM_WE_N = ~write_active;
    SRAM_addr = '0;
    case (state_reg)
      IDLE: begin
        Ready = ~(fill_active | write_active);
        if (req_r && hit) data_mem = rdata;
      end
      DONE: begin
        Ready = 1'b1;
        if (Mem_R_EN && !Mem_W_EN) begin
          data_mem = word_sel ? {line_buf[3], line_buf[2]} : {line_buf[1], line_buf[0]};
        end
      end
      default: Ready = 1'b0;
    endcase
    if (fill_active) begin
      SRAM_addr = line_hw[SRAM_AW-1:0] + hw_off;
    end else if (write_active) begin
      SRAM_addr = word_hw[SRAM_AW-1:0] + hw_off;
    end
  end

  assign SRAM_data = SRAM_WE_N ? 16'bz : (hw_cnt_reg[0] ? Val_Rm[31:16] : Val_Rm[15:0]);
  assign WB_EN_OUT = WB_EN_IN & Ready;

  logic unused_bits;
  assign unused_bits = &{1'b0, a[1:0], line_hw, word_hw};

endmodule

// File: tb/tb_mem_stage_assoc.sv
// Self-checking bench for mem_stage_assoc: table of load/store transactions
// with a scoreboard queue, plus reset and reset-during-fill sequences.
module tb_mem_stage_assoc;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ALU_res, Val_Rm;
  logic        Mem_R_EN, Mem_W_EN, WB_EN_IN;
  wire  [15:0] SRAM_data;
  logic        SRAM_WE_N;
  logic [17:0] SRAM_addr;
  logic        Ready;
  logic [31:0] data_mem;
  logic        WB_EN_OUT;

  always #5 clk = ~clk;

  mem_stage_assoc dut (
    .clk       (clk),
    .rst       (rst),
    .ALU_res   (ALU_res),
    .Val_Rm    (Val_Rm),
    .Mem_R_EN  (Mem_R_EN),
    .Mem_W_EN  (Mem_W_EN),
    .WB_EN_IN  (WB_EN_IN),
    .SRAM_data (SRAM_data),
    .SRAM_WE_N (SRAM_WE_N),
    .SRAM_addr (SRAM_addr),
    .Ready     (Ready),
    .data_mem  (data_mem),
    .WB_EN_OUT (WB_EN_OUT)
  );

  // ---------------- SRAM model ----------------
  typedef struct {
    logic [17:0] addr;
    logic [15:0] data;
  } wr_t;

  logic [15:0] sram [4096];
  bit          sram_ready;
  wr_t         wlog[$];

  function automatic logic [15:0] init_hw(input int i);
    case (i)
      0: return 16'h0000;
      1: return 16'h1111;
      2: return 16'h2222;
      3: return 16'h3333;
      default: return 16'(i * 3 + 4096);
    endcase
  endfunction

  function automatic logic [31:0] init_word(input logic [31:0] addr);
    int hw;
    hw = int'((addr - 32'd1024) >> 1);
    return {init_hw(hw + 1), init_hw(hw)};
  endfunction

  function automatic wr_t mk_wr(input logic [17:0] a, input logic [15:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    return w;
  endfunction

  assign SRAM_data = SRAM_WE_N ? sram[SRAM_addr[11:0]] : 16'hzzzz;

  always @(posedge clk) begin
    if (!sram_ready) begin
      for (int i = 0; i < 4096; i++) sram[i] <= init_hw(i);
      sram_ready <= 1'b1;
    end else if (!SRAM_WE_N) begin
      sram[SRAM_addr[11:0]] <= SRAM_data;
      if (wlog.size() == 0 || wlog[$].addr != SRAM_addr)
        wlog.push_back(mk_wr(SRAM_addr, SRAM_data));
    end
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  typedef struct {
    bit          is_store;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    int          exp_stall;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];

  function automatic vec_t mk(input bit st, input logic [31:0] ad, input logic [31:0] wd,
                              input logic [31:0] ed, input int es);
    vec_t v;
    v.is_store  = st;
    v.addr      = ad;
    v.wdata     = wd;
    v.exp_data  = ed;
    v.exp_stall = es;
    return v;
  endfunction

  // Drives one transaction (called just after a rising edge), waits for Ready,
  // then pops the scoreboard entry and compares.
  task automatic run_op(input int n, input vec_t v);
    vec_t e;
    int   stall, wb_low, we_low;
    bit   done;
    logic [17:0] whw;
    ALU_res  = v.addr;
    Val_Rm   = v.wdata;
    Mem_R_EN = !v.is_store;
    Mem_W_EN = v.is_store;
    WB_EN_IN = 1'b1;
    wlog.delete();
    sb.push_back(v);
    stall = 0; wb_low = 0; we_low = 0; done = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      if (Ready) done = 1'b1;
      else begin
        stall++;
        if (!WB_EN_OUT) wb_low++;
        if (!SRAM_WE_N) we_low++;
      end
    end
    e = sb.pop_front();
    check($sformatf("op%0d_ready_seen", n), 32'(done), 32'd1);
    check($sformatf("op%0d_stall", n), 32'(stall), 32'(e.exp_stall));
    check($sformatf("op%0d_wb_low", n), 32'(wb_low), 32'(e.exp_stall));
    check($sformatf("op%0d_wb_done", n), 32'(WB_EN_OUT), 32'd1);
    check($sformatf("op%0d_we_n_done", n), 32'(SRAM_WE_N), 32'd1);
    if (!e.is_store) begin
      check($sformatf("op%0d_data", n), data_mem, e.exp_data);
      check($sformatf("op%0d_we_low", n), 32'(we_low), 32'd0);
    end else begin
      whw = 18'((e.addr - 32'd1024) >> 1) & ~18'd1;
      check($sformatf("op%0d_we_low", n), 32'(we_low), 32'd10);
      check($sformatf("op%0d_wr_count", n), 32'(wlog.size()), 32'd2);
      if (wlog.size() == 2) begin
        check($sformatf("op%0d_wr0", n), {wlog[0].addr[15:0], wlog[0].data}, {whw[15:0], e.wdata[15:0]});
        check($sformatf("op%0d_wr1", n), {wlog[1].addr[15:0], wlog[1].data}, {whw[15:0] + 16'd1, e.wdata[31:16]});
      end
    end
    $display("op%0d %s addr=%0d stall=%0d data_mem=0x%08h", n, e.is_store ? "ST" : "LD",
             e.addr, stall, data_mem);
    @(posedge clk);
    #1;
    Mem_R_EN = 1'b0;
    Mem_W_EN = 1'b0;
    WB_EN_IN = 1'b0;
  endtask

  initial begin
    rst = 1'b1; ALU_res = 32'd0; Val_Rm = 32'd0;
    Mem_R_EN = 1'b0; Mem_W_EN = 1'b0; WB_EN_IN = 1'b1;

    // Table: cold miss/hit, LRU eviction in set 0, store hit, store miss.
    vecs.push_back(mk(0, 32'd1024, 32'd0, 32'h1111_0000, 20));
    vecs.push_back(mk(0, 32'd1028, 32'd0, 32'h3333_2222, 0));
    vecs.push_back(mk(0, 32'd1536, 32'd0, init_word(32'd1536), 20));
    vecs.push_back(mk(0, 32'd2048, 32'd0, init_word(32'd2048), 20));
    vecs.push_back(mk(0, 32'd1536, 32'd0, init_word(32'd1536), 0));
    vecs.push_back(mk(0, 32'd1024, 32'd0, 32'h1111_0000, 20));
    vecs.push_back(mk(0, 32'd1536, 32'd0, init_word(32'd1536), 0));
    vecs.push_back(mk(1, 32'd1024, 32'hDEAD_BEEF, 32'd0, 10));
    vecs.push_back(mk(0, 32'd1024, 32'd0, 32'hDEAD_BEEF, 0));
    vecs.push_back(mk(0, 32'd1028, 32'd0, 32'h3333_2222, 0));
    vecs.push_back(mk(1, 32'd2048, 32'h0000_00AA, 32'd0, 10));
    vecs.push_back(mk(0, 32'd2048, 32'd0, 32'h0000_00AA, 20));
    vecs.push_back(mk(0, 32'd1024, 32'd0, 32'hDEAD_BEEF, 0));

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(Ready), 32'd1);
    check("rst_data_mem", data_mem, 32'd0);
    check("rst_we_n", 32'(SRAM_WE_N), 32'd1);
    check("rst_sram_addr", 32'(SRAM_addr), 32'd0);
    check("rst_wb_en_out", 32'(WB_EN_OUT), 32'd1);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("idle_data_mem", data_mem, 32'd0);

    foreach (vecs[i]) run_op(i, vecs[i]);

    // Reset in the middle of a fill: outputs return to idle at once, no install.
    ALU_res  = 32'd1040;
    Mem_R_EN = 1'b1;
    WB_EN_IN = 1'b1;
    repeat (7) @(negedge clk);
    check("midfill_ready_low", 32'(Ready), 32'd0);
    check("midfill_addr", 32'(SRAM_addr), 32'd9);
    rst = 1'b1;
    #1;
    check("midfill_rst_ready", 32'(Ready), 32'd1);
    check("midfill_rst_we_n", 32'(SRAM_WE_N), 32'd1);
    check("midfill_rst_addr", 32'(SRAM_addr), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    Mem_R_EN = 1'b0;
    @(posedge clk);
    #1;
    run_op(100, mk(0, 32'd1040, 32'd0, init_word(32'd1040), 20));
    run_op(101, mk(0, 32'd1024, 32'd0, 32'hDEAD_BEEF, 20));
    run_op(102, mk(0, 32'd1044, 32'd0, init_word(32'd1044), 0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
